// File: rtl/aes_round_engine.sv
// ---------------------------------------------------------------------------
// aes_round_engine
//   Iterative AES encryption core: one full round per clock for AES-128/192/256
//   (NR = 10/12/14). A plaintext block is accepted over a valid/ready handshake
//   together with a pre-expanded round-key bus; the ciphertext is returned over
//   a second valid/ready handshake that honours backpressure.
//
// Ports
//   clk        system clock
//   resetn     synchronous active-low reset
//   s_valid    input block valid
//   s_ready    engine can accept a block (combinational)
//   s_data     plaintext, byte 0 = s_data[127:120], FIPS-197 column-major
//   round_keys flattened round keys, key r = round_keys[RKW-1-128*r -: 128]
//   m_valid    ciphertext valid (registered)
//   m_ready    downstream accepts ciphertext
//   m_data     ciphertext (registered), same byte order as s_data
//   busy       high while rounds are being computed
//   round      current round index (debug)
//
// aes_sbox
//   Combinational AES S-box: multiplicative inverse in GF(2^8) mod 0x11B
//   followed by the FIPS-197 affine transform.
//
// Ports
//   in_i   byte to substitute
//   out_o  substituted byte
// ---------------------------------------------------------------------------

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  logic [7:0] x2, x3, x12, x15, x240, inv;

  // Inverse as x^254 through an addition chain; 0 maps to 0 naturally.
  always_comb begin
    x2   = gf_mul(in_i, in_i);
    x3   = gf_mul(x2, in_i);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    out_o = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  end

endmodule

module aes_round_engine #(
  parameter int NR  = 10,
  parameter int RKW = 128 * (NR + 1)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [127:0]   s_data,
  input  logic [RKW-1:0] round_keys,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [127:0]   m_data,
  output logic           busy,
  output logic [3:0]     round
);

  generate
    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
      $error("aes_round_engine: NR must be 10, 12 or 14");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] mdata_q, mdata_d;
  logic [3:0]   round_q, round_d;

  logic [127:0] sub, sr, mc, rk_cur, rk0;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // ---- stage: SubBytes on the registered state ----
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (blk_q[127-8*i -: 8]),
      .out_o (sub[127-8*i -: 8])
    );
  end

  // ---- stage: ShiftRows, byte (r,c) takes byte (r, c+r mod 4) ----
  for (genvar c = 0; c < 4; c++) begin : g_sr_col
    for (genvar r = 0; r < 4; r++) begin : g_sr_row
      assign sr[127-8*(4*c+r) -: 8] = sub[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end

  // ---- stage: MixColumns ----
  for (genvar c = 0; c < 4; c++) begin : g_mc
    assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  // ---- stage: round-key select ----
  assign rk0 = round_keys[RKW-1 -: 128];

  always_comb begin
    rk_cur = '0;
    for (int r = 0; r <= NR; r++) begin
      if (round_q == 4'(r)) rk_cur = round_keys[RKW-1-128*r -: 128];
    end
  end

  // ---- stage: control and next state ----
  always_comb begin
    fsm_d   = fsm_q;
    blk_d   = blk_q;
    mdata_d = mdata_q;
    round_d = round_q;
    s_ready = 1'b0;
    case (fsm_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          blk_d   = s_data ^ rk0;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (round_q == 4'(NR)) begin
          // Final round drops MixColumns.
          mdata_d = sr ^ rk_cur;
          round_d = 4'd0;
          fsm_d   = DONE;
        end else begin
          blk_d   = mc ^ rk_cur;
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        // A consumed output frees the engine for a same-edge accept.
        s_ready = m_ready;
        if (m_ready) begin
          if (s_valid) begin
            blk_d   = s_data ^ rk0;
            round_d = 4'd1;
            fsm_d   = ROUND;
          end else begin
            fsm_d = IDLE;
          end
        end
      end
      default: begin
        fsm_d   = IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  // ---- stage: registers ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      fsm_q   <= IDLE;
      blk_q   <= '0;
      mdata_q <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      blk_q   <= blk_d;
      mdata_q <= mdata_d;
      round_q <= round_d;
    end
  end

  assign m_valid = (fsm_q == DONE);
  assign busy    = (fsm_q == ROUND);
  assign m_data  = mdata_q;
  assign round   = round_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// ---------------------------------------------------------------------------
// tb_aes_round_engine
//   Bench for aes_round_engine. Three instances (NR = 10, 12, 14) share clock
//   and reset. A byte-level AES model (generated S-box table, FIPS-197 key
//   expansion, textbook round steps) supplies expected ciphertexts.
// ---------------------------------------------------------------------------

module tb_aes_round_engine;

  logic clk;
  logic resetn;

  logic [2:0]   s_valid;
  logic [2:0]   m_ready;
  logic [127:0] s_data [3];
  wire  [2:0]   s_ready;
  wire  [2:0]   m_valid;
  wire  [2:0]   busy;
  wire  [127:0] m_data [3];
  wire  [3:0]   rnd [3];

  logic [1407:0] rk10;
  logic [1663:0] rk12;
  logic [1919:0] rk14;

  int nvec;
  int nerr;

  logic [7:0] sbox_t [256];

  aes_round_engine #(.NR(10)) dut10 (
    .clk(clk), .resetn(resetn), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .round_keys(rk10), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
    .m_data(m_data[0]), .busy(busy[0]), .round(rnd[0]));

  aes_round_engine #(.NR(12)) dut12 (
    .clk(clk), .resetn(resetn), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .round_keys(rk12), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
    .m_data(m_data[1]), .busy(busy[1]), .round(rnd[1]));

  aes_round_engine #(.NR(14)) dut14 (
    .clk(clk), .resetn(resetn), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .s_data(s_data[2]), .round_keys(rk14), .m_valid(m_valid[2]), .m_ready(m_ready[2]),
    .m_data(m_data[2]), .busy(busy[2]), .round(rnd[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // S-box table via generator 3 walk: p runs over 3^k, q over 3^-k.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  // Key left-aligned in 256 bits; round key r at out[1919-128*r -: 128].
  function automatic logic [1919:0] expand(input logic [255:0] key, input int nr);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] o;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    o  = '0;
    for (int i = 0; i < 60; i++) w[i] = 0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int i = 0; i < 4*(nr+1); i++) o[1919-32*i -: 32] = w[i];
    return o;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1919:0] rks, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rks[1919-8*i -: 8];
    for (int rn = 1; rn <= nr; rn++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rn < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = s[4*c+r];
          for (int r = 0; r < 4; r++)
            s[4*c+r] = gmul(8'h02, a[r]) ^ gmul(8'h03, a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] ^= rks[1919-128*rn-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Entered and left 1 time unit after a rising edge. Leaves the engine in
  // DONE with m_ready low; lat counts edges from accept to m_valid.
  task automatic run_block(input int sel, input logic [127:0] pt,
                           output logic [127:0] ct, output int lat);
    s_valid[sel] = 1'b1;
    s_data[sel]  = pt;
    m_ready[sel] = 1'b0;
    @(posedge clk);
    #1;
    s_valid[sel] = 1'b0;
    s_data[sel]  = rnd128();
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (m_valid[sel]) break;
    end
    ct = m_data[sel];
  endtask

  task automatic consume(input int sel);
    m_ready[sel] = 1'b1;
    @(posedge clk);
    #1;
    m_ready[sel] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if ({m_valid[k], busy[k], s_ready[k], rnd[k], m_data[k]} !== {1'b0, 1'b0, 1'b1, 4'd0, 128'd0}) begin
        nerr++;
        $display("FAIL reset_state inst%0d: got mv=%b busy=%b srdy=%b round=%0d md=%h, need 0 0 1 0 0",
                 k, m_valid[k], busy[k], s_ready[k], rnd[k], m_data[k]);
      end
    end
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_kat();
    logic [127:0] ct;
    logic [127:0] pt;
    int lat;
    pt   = 128'h00112233445566778899aabbccddeeff;
    rk10 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10) >> 512;
    rk12 = expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 12) >> 256;
    rk14 = expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
    run_block(0, pt, ct, lat);
    nvec++;
    if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
      nerr++; $display("FAIL kat128_data: got %h need 69c4e0d86a7b0430d8cdb78070b4c55a", ct);
    end
    nvec++;
    if (lat !== 10) begin nerr++; $display("FAIL kat128_latency: got %0d need 10", lat); end
    consume(0);
    run_block(1, pt, ct, lat);
    nvec++;
    if (ct !== 128'hdda97ca4864cdfe06eaf70a0ec0d7191) begin
      nerr++; $display("FAIL kat192_data: got %h need dda97ca4864cdfe06eaf70a0ec0d7191", ct);
    end
    nvec++;
    if (lat !== 12) begin nerr++; $display("FAIL kat192_latency: got %0d need 12", lat); end
    consume(1);
    run_block(2, pt, ct, lat);
    nvec++;
    if (ct !== 128'h8ea2b7ca516745bfeafc49904b496089) begin
      nerr++; $display("FAIL kat256_data: got %h need 8ea2b7ca516745bfeafc49904b496089", ct);
    end
    nvec++;
    if (lat !== 14) begin nerr++; $display("FAIL kat256_latency: got %0d need 14", lat); end
    consume(2);
  endtask

  task automatic test_random();
    logic [1919:0] e;
    logic [255:0]  key;
    logic [127:0]  pt, ct, exp_ct;
    int lat;
    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 3; k++) begin
        key = rnd256();
        pt  = rnd128();
        e   = expand(key, 10 + 2*k);
        if (k == 0) rk10 = e[1919 -: 1408];
        else if (k == 1) rk12 = e[1919 -: 1664];
        else rk14 = e;
        exp_ct = aes_ref(pt, e, 10 + 2*k);
        run_block(k, pt, ct, lat);
        nvec++;
        if (ct !== exp_ct || lat !== 10 + 2*k) begin
          nerr++;
          $display("FAIL random_block inst%0d #%0d: got %h lat %0d, need %h lat %0d",
                   k, n, ct, lat, exp_ct, 10 + 2*k);
        end
        consume(k);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1919:0] e;
    logic [127:0]  pt, ct, exp_ct;
    int lat;
    e    = expand(rnd256(), 10);
    rk10 = e[1919 -: 1408];
    pt   = rnd128();
    exp_ct = aes_ref(pt, e, 10);
    run_block(0, pt, ct, lat);
    nvec++;
    if (ct !== exp_ct) begin nerr++; $display("FAIL bp_data: got %h need %h", ct, exp_ct); end
    s_valid[0] = 1'b1;
    s_data[0]  = rnd128();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      nvec++;
      if ({m_valid[0], s_ready[0], busy[0], m_data[0]} !== {1'b1, 1'b0, 1'b0, exp_ct}) begin
        nerr++;
        $display("FAIL bp_hold cycle %0d: got mv=%b srdy=%b busy=%b md=%h, need 1 0 0 %h",
                 i, m_valid[0], s_ready[0], busy[0], m_data[0], exp_ct);
      end
    end
    s_valid[0] = 1'b0;
    consume(0);
    nvec++;
    if ({m_valid[0], s_ready[0], busy[0]} !== 3'b010) begin
      nerr++;
      $display("FAIL bp_release: got mv=%b srdy=%b busy=%b, need 0 1 0", m_valid[0], s_ready[0], busy[0]);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      nvec++;
      if (m_valid[0] !== 1'b0) begin nerr++; $display("FAIL bp_single_transfer cycle %0d: m_valid got %b need 0", i, m_valid[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1919:0] e;
    logic [127:0]  pts [4];
    logic [127:0]  exps [4];
    int idx, outcnt, cyc, last;
    logic acc, xfer;
    e    = expand(rnd256(), 10);
    rk10 = e[1919 -: 1408];
    for (int i = 0; i < 4; i++) begin
      pts[i]  = rnd128();
      exps[i] = aes_ref(pts[i], e, 10);
    end
    idx = 0; outcnt = 0; cyc = 0; last = 0;
    while (outcnt < 4 && cyc < 200) begin
      s_valid[0]  = (idx < 4);
      s_data[0]   = (idx < 4) ? pts[idx] : rnd128();
      m_ready[0]  = 1'b1;
      #1;
      acc  = s_valid[0] && s_ready[0];
      xfer = m_valid[0] && m_ready[0];
      if (xfer) begin
        nvec++;
        if (m_data[0] !== exps[outcnt]) begin
          nerr++; $display("FAIL b2b_data #%0d: got %h need %h", outcnt, m_data[0], exps[outcnt]);
        end
        if (outcnt > 0) begin
          nvec++;
          if (cyc - last !== 11) begin nerr++; $display("FAIL b2b_spacing #%0d: got %0d need 11", outcnt, cyc - last); end
        end
        last = cyc;
        outcnt++;
      end
      @(posedge clk);
      cyc++;
      if (acc) idx++;
      #1;
    end
    s_valid[0] = 1'b0;
    nvec++;
    if (outcnt !== 4 || idx !== 4) begin
      nerr++; $display("FAIL b2b_count: got %0d outputs %0d accepts, need 4 4", outcnt, idx);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      nvec++;
      if (m_valid[0] !== 1'b0) begin nerr++; $display("FAIL b2b_no_duplicate cycle %0d: m_valid got %b need 0", i, m_valid[0]); end
    end
    m_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [1919:0] e;
    logic [127:0]  pt, ct, exp_ct;
    int lat, n;
    e    = expand(rnd256(), 10);
    rk10 = e[1919 -: 1408];
    s_valid[0] = 1'b1;
    s_data[0]  = rnd128();
    @(posedge clk);
    #1;
    s_valid[0] = 1'b0;
    n = 0;
    while (rnd[0] !== 4'd5 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    nvec++;
    if (rnd[0] !== 4'd5) begin nerr++; $display("FAIL rst_mid_reach_round5: round got %0d need 5", rnd[0]); end
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    nvec++;
    if ({m_valid[0], busy[0], rnd[0], s_ready[0], m_data[0]} !== {1'b0, 1'b0, 4'd0, 1'b1, 128'd0}) begin
      nerr++;
      $display("FAIL rst_mid_state: got mv=%b busy=%b round=%0d srdy=%b md=%h, need 0 0 0 1 0",
               m_valid[0], busy[0], rnd[0], s_ready[0], m_data[0]);
    end
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      nvec++;
      if (m_valid[0] !== 1'b0) begin nerr++; $display("FAIL rst_mid_discard cycle %0d: m_valid got %b need 0", i, m_valid[0]); end
    end
    pt = rnd128();
    exp_ct = aes_ref(pt, e, 10);
    run_block(0, pt, ct, lat);
    nvec++;
    if (ct !== exp_ct || lat !== 10) begin
      nerr++; $display("FAIL rst_mid_recover: got %h lat %0d, need %h lat 10", ct, lat, exp_ct);
    end
    consume(0);
  endtask

  task automatic test_idle();
    logic [127:0]  md;
    logic [1407:0] keep;
    keep = rk10;
    md   = m_data[0];
    s_valid[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s_data[0] = rnd128();
      for (int w = 0; w < 44; w++) rk10[32*w +: 32] = $urandom;
      @(posedge clk);
      #1;
      nvec++;
      if ({m_valid[0], s_ready[0], busy[0], rnd[0], m_data[0]} !== {1'b0, 1'b1, 1'b0, 4'd0, md}) begin
        nerr++;
        $display("FAIL idle_hold cycle %0d: got mv=%b srdy=%b busy=%b round=%0d md=%h, need 0 1 0 0 %h",
                 i, m_valid[0], s_ready[0], busy[0], rnd[0], m_data[0], md);
      end
    end
    rk10 = keep;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    resetn  = 1'b0;
    s_valid = '0;
    m_ready = '0;
    for (int k = 0; k < 3; k++) s_data[k] = '0;
    rk10 = '0;
    rk12 = '0;
    rk14 = '0;
    build_sbox();
    test_reset();
    test_kat();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
